ifu: RTL



---
 rtl/ifu.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ifu.sv
// Instruction fetch unit: issues one fetch at a time on the imem request
// channel, waits (bounded) for the response, holds the instruction for decode,
// then fetches from the next_pc that decode supplies on consume.
// Faults (bus error, misaligned next_pc, response timeout) park the unit in a
// sticky error state until reset.
//
// Ports:
//   clk, rst           clock, synchronous active-low reset
//   imem_req_*         fetch request channel (valid/ready, 32-bit address)
//   imem_rsp_*         fetch response (valid, 32-bit data, bus error flag)
//   inst_valid/ready   handshake with decode; inst/pc carry the held word
//   next_pc            next fetch address, sampled only on consume
//   fetch_err[_code]   sticky fault flag and 2-bit fault code
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    input  logic [31:0] next_pc,
    output logic        fetch_err,
    output logic [1:0]  fetch_err_code
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // Count value seen in the last permitted WAIT cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_BUS     = 2'b01;
    localparam logic [1:0] ERR_ALIGN   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   w_pc_nxt;
    logic [XLEN-1:0]   r_inst;
    logic [XLEN-1:0]   w_inst_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [1:0]        r_err_code;
    logic [1:0]        w_err_code_nxt;
    logic              r_req_valid;
    logic              r_inst_valid;
    logic              r_fetch_err;

    // Next-state and datapath update.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_inst_nxt     = r_inst;
        w_cnt_nxt      = r_cnt;
        w_err_code_nxt = r_err_code;
        case (r_state)
            S_REQ: begin
                // r_req_valid is low for one cycle after reset, so no
                // acceptance can happen before the request is actually shown.
                if (r_req_valid && imem_req_ready) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            S_WAIT: begin
                // A response beats the timeout in the same cycle.
                if (imem_rsp_valid) begin
                    if (imem_rsp_err) begin
                        w_state_nxt    = S_ERR;
                        w_err_code_nxt = ERR_BUS;
                    end else begin
                        w_state_nxt = S_HOLD;
                        w_inst_nxt  = imem_rsp_data;
                    end
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt    = S_ERR;
                    w_err_code_nxt = ERR_TIMEOUT;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (r_inst_valid && inst_ready) begin
                    if (next_pc[1:0] == 2'b00) begin
                        w_state_nxt = S_REQ;
                        w_pc_nxt    = next_pc;
                    end else begin
                        w_state_nxt    = S_ERR;
                        w_err_code_nxt = ERR_ALIGN;
                    end
                end
            end
            default: begin
                w_state_nxt = S_ERR;
            end
        endcase
    end

    // State and registered outputs; outputs are decoded from the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_inst       <= '0;
            r_cnt        <= '0;
            r_err_code   <= ERR_NONE;
            r_req_valid  <= 1'b0;
            r_inst_valid <= 1'b0;
            r_fetch_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_inst       <= w_inst_nxt;
            r_cnt        <= w_cnt_nxt;
            r_err_code   <= w_err_code_nxt;
            r_req_valid  <= (w_state_nxt == S_REQ);
            r_inst_valid <= (w_state_nxt == S_HOLD);
            r_fetch_err  <= (w_state_nxt == S_ERR);
        end
    end

    assign imem_req_valid = r_req_valid;
    assign imem_req_addr  = r_pc;
    assign inst_valid     = r_inst_valid;
    assign inst           = r_inst;
    assign pc             = r_pc;
    assign fetch_err      = r_fetch_err;
    assign fetch_err_code = r_err_code;

endmodule
